lcd_write_strobe_gen: RTL

//  Parametrised HD44780 write-cycle generator for the Spartan-3E 4-bit character-LCD bus.

---
 rtl/lcd_write_strobe_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/lcd_write_strobe_gen.sv
// HD44780 4-bit bus write-cycle generator.
// Emits one or two E strobes per request with programmable setup, pulse,
// hold, inter-nibble gap and post-write settle times, then a done pulse.
module lcd_write_strobe_gen #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned PULSE_CYCLES = 12,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned GAP_CYCLES   = 50,
  parameter int unsigned WAIT_CYCLES  = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic [7:0] iData,
  input  logic       iNibbleOnly,
  output logic       oBusy,
  output logic       oDone,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_D
);

  // Terminal count of each timed state; a zero-length request still lasts one cycle.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SETUP_CYCLES == 0) ? 0 : SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'((PULSE_CYCLES == 0) ? 0 : PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((HOLD_CYCLES  == 0) ? 0 : HOLD_CYCLES  - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES   == 0) ? 0 : GAP_CYCLES   - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((WAIT_CYCLES  == 0) ? 0 : WAIT_CYCLES  - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_GAP,
    S_WAIT
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [3:0]       lowNibble;
  logic             lowPending;

  // Write-only bus.
  assign oLCD_RW = 1'b0;

  // Next-state and counter: each timed state advances when its counter reaches the terminal count.
  always_comb begin
    stateNext = state;
    cntNext   = cnt + CNT_W'(1);
    case (state)
      S_IDLE:  if (iStart) stateNext = S_SETUP;
      S_SETUP: if (cnt == SETUP_LAST) stateNext = S_PULSE;
      S_PULSE: if (cnt == PULSE_LAST) stateNext = S_HOLD;
      S_HOLD:  if (cnt == HOLD_LAST) stateNext = lowPending ? S_GAP : S_WAIT;
      S_GAP:   if (cnt == GAP_LAST) stateNext = S_SETUP;
      S_WAIT:  if (cnt == WAIT_LAST) stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
    if (stateNext != state || state == S_IDLE) cntNext = '0;
  end

  // State, latched transfer and outputs; outputs are decoded from the next state so they line up with it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lowNibble  <= '0;
      lowPending <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oLCD_E     <= 1'b0;
      oLCD_RS    <= 1'b0;
      oLCD_D     <= '0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      oBusy  <= (stateNext != S_IDLE);
      oDone  <= (state == S_WAIT) && (stateNext == S_IDLE);
      oLCD_E <= (stateNext == S_PULSE);
      if (state == S_IDLE && iStart) begin
        oLCD_RS    <= iRS;
        oLCD_D     <= iData[7:4];
        lowNibble  <= iData[3:0];
        lowPending <= !iNibbleOnly;
      end
      if (state == S_HOLD && stateNext == S_GAP) lowPending <= 1'b0;
      if (state == S_GAP && stateNext == S_SETUP) oLCD_D <= lowNibble;
    end
  end

endmodule
